// File: rtl/ac_motor_ramp_control.sv
// ac_motor_ramp_control: bootstrap, V/f ramp and fault sequencer for the inverter chain (option: AC_MOTOR_RAMP_CTRL_BOOST_EN adds V_BOOST to u_str)
module ac_motor_ramp_control #(
  parameter int BOOT_CYCLES = 5000,
  parameter int FREQ_STEP   = 1,
  parameter int VF_GAIN     = 256,
  parameter int V_BOOST     = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        fault_in,
  input  logic        clear_fault,
  input  logic [11:0] target_freq,
  input  logic [15:0] ramp_div,
  output logic [11:0] frequency,
  output logic [11:0] u_str,
  output logic        enable,
  output logic        boot_low,
  output logic        running,
  output logic        fault,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, BOOT = 3'd1, RAMP = 3'd2, RUN = 3'd3, STOP = 3'd4, FAULT = 3'd5} state_t;
  localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [11:0] STEP = 12'(FREQ_STEP);
`ifdef AC_MOTOR_RAMP_CTRL_BOOST_EN
  localparam bit BOOST_EN = 1'b1;
`else
  localparam bit BOOST_EN = 1'b0;
`endif
  localparam logic [20:0] BOOST = BOOST_EN ? 21'(V_BOOST) : 21'd0;
  state_t state_q, state_d;
  logic [11:0] freq_q, freq_d, u_str_q, u_str_d, diff, toward, down;
  logic [15:0] presc_q, presc_d, div_q, div_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [20:0] vf, v_sum;
  logic tick, up;
  assign tick   = presc_q == div_q;
  assign up     = target_freq > freq_q;
  assign diff   = up ? target_freq - freq_q : freq_q - target_freq;
  assign toward = diff < STEP ? target_freq : up ? freq_q + STEP : freq_q - STEP;
  assign down   = freq_q < STEP ? '0 : freq_q - STEP;
  assign vf      = 21'(freq_q) * 21'(VF_GAIN);
  assign v_sum   = (vf >> 8) + BOOST;
  assign u_str_d = !(state_d inside {RAMP, RUN, STOP}) ? '0 : (v_sum > 21'd4095 ? 12'hFFF : v_sum[11:0]);
  // Sequencer: state transitions, frequency ramp, boot countdown and ramp prescaler
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    boot_d  = boot_q;
    presc_d = tick ? '0 : presc_q + 16'd1;
    div_d   = tick ? ramp_div : div_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = BOOT;
        boot_d  = BW'(BOOT_CYCLES - 1);
      end
      BOOT: if (stop) state_d = IDLE;
        else if (boot_q == '0) state_d = RAMP;
        else boot_d = boot_q - BW'(1);
      RAMP: if (stop) state_d = STOP;
        else if (freq_q == target_freq) state_d = RUN;
        else if (tick) freq_d = toward;
      RUN: if (stop) state_d = STOP;
        else if (target_freq != freq_q) state_d = RAMP;
      STOP: if (freq_q == '0) state_d = IDLE;
        else if (tick) freq_d = down;
      FAULT: if (clear_fault && !fault_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fault_in) begin
      state_d = FAULT;
      freq_d  = '0;
    end
    if (state_d != state_q || !(state_d inside {RAMP, STOP})) begin
      presc_d = '0;
      div_d   = ramp_div;
    end
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      freq_q  <= '0;
      u_str_q <= '0;
      presc_q <= '0;
      div_q   <= '0;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      u_str_q <= u_str_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      boot_q  <= boot_d;
    end
  end
  assign frequency = freq_q;
  assign u_str     = u_str_q;
  assign enable    = state_q inside {RAMP, RUN, STOP};
  assign boot_low  = state_q == BOOT;
  assign running   = state_q == RUN;
  assign fault     = state_q == FAULT;
  assign state     = state_q;
endmodule

// File: tb/tb_ac_motor_ramp_control.sv
// tb_ac_motor_ramp_control: directed checks of boot, ramp, stop, fault, saturation and reset
module tb_ac_motor_ramp_control;
  logic clk = 0, rst = 1, stop = 0, fault_in = 0, clear_fault = 0;
  logic start_a = 0, start_b = 0, start_c = 0;
  logic [11:0] target_freq = 0;
  logic [15:0] ramp_div = 0;
  logic [11:0] f_a, u_a, f_b, u_b, f_c, u_c;
  logic en_a, bl_a, run_a, flt_a, en_b, bl_b, run_b, flt_b, en_c, bl_c, run_c, flt_c;
  logic [2:0] st_a, st_b, st_c;
  int n_tests = 0, n_fail = 0;
`ifdef AC_MOTOR_RAMP_CTRL_BOOST_EN
  localparam int BA = 100;
  localparam int BC = 200;
`else
  localparam int BA = 0;
  localparam int BC = 0;
`endif
  always #5 clk = ~clk;
  ac_motor_ramp_control #(.BOOT_CYCLES(8), .FREQ_STEP(1), .VF_GAIN(256), .V_BOOST(100)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop), .fault_in(fault_in), .clear_fault(clear_fault),
    .target_freq(target_freq), .ramp_div(ramp_div), .frequency(f_a), .u_str(u_a), .enable(en_a),
    .boot_low(bl_a), .running(run_a), .fault(flt_a), .state(st_a));
  ac_motor_ramp_control #(.BOOT_CYCLES(8), .FREQ_STEP(3), .VF_GAIN(256), .V_BOOST(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .fault_in(fault_in), .clear_fault(clear_fault),
    .target_freq(target_freq), .ramp_div(ramp_div), .frequency(f_b), .u_str(u_b), .enable(en_b),
    .boot_low(bl_b), .running(run_b), .fault(flt_b), .state(st_b));
  ac_motor_ramp_control #(.BOOT_CYCLES(8), .FREQ_STEP(4095), .VF_GAIN(511), .V_BOOST(200)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .stop(stop), .fault_in(fault_in), .clear_fault(clear_fault),
    .target_freq(target_freq), .ramp_div(ramp_div), .frequency(f_c), .u_str(u_c), .enable(en_c),
    .boot_low(bl_c), .running(run_c), .fault(flt_c), .state(st_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic [11:0] lo;
    step(2);
    rst = 0;
    step(1);
    chk("rst_state", st_a, 0);
    chk("rst_freq", f_a, 0);
    chk("rst_u", u_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_boot", bl_a, 0);
    chk("rst_fault", flt_a, 0);
    chk("rst_run", run_a, 0);
    target_freq = 10;
    ramp_div = 3;
    start_a = 1;
    step(1);
    start_a = 0;
    chk("boot_state", st_a, 1);
    chk("boot_en", en_a, 0);
    n = 0;
    while (bl_a && n < 100) begin n++; step(1); end
    chk("boot_len", n, 8);
    chk("ramp_state", st_a, 2);
    chk("ramp_en", en_a, 1);
    chk("ramp_u0", u_a, BA);
    n = 0;
    while (f_a != 10 && n < 200) begin step(1); n++; end
    chk("ramp_cycles", n, 40);
    chk("pre_run", run_a, 0);
    step(1);
    chk("run", run_a, 1);
    chk("run_u", u_a, 10 + BA);
    target_freq = 4;
    step(1);
    chk("down_state", st_a, 2);
    step(3);
    chk("down_hold", f_a, 10);
    step(1);
    chk("down_tick", f_a, 9);
    lo = f_a;
    n = 0;
    while (!run_a && n < 200) begin step(1); n++; if (f_a < lo) lo = f_a; end
    chk("down_cycles", n, 21);
    chk("down_min", lo, 4);
    chk("down_freq", f_a, 4);
    target_freq = 10;
    n = 0;
    while (!(run_a && f_a == 10) && n < 200) begin step(1); n++; end
    chk("back_up", f_a, 10);
    stop = 1;
    start_a = 1;
    step(1);
    chk("stop_state", st_a, 4);
    chk("stop_en", en_a, 1);
    n = 0;
    while (st_a == 4 && n < 200) begin step(1); n++; end
    chk("stop_cycles", n, 41);
    chk("stop_idle", st_a, 0);
    chk("stop_en_off", en_a, 0);
    chk("stop_freq", f_a, 0);
    chk("stop_u", u_a, 0);
    step(2);
    chk("start_blocked", st_a, 0);
    stop = 0;
    step(1);
    chk("restart", st_a, 1);
    start_a = 0;
    n = 0;
    while (f_a < 2 && n < 200) begin step(1); n++; end
    chk("pre_fault_state", st_a, 2);
    fault_in = 1;
    step(1);
    chk("flt_state", st_a, 5);
    chk("flt_en", en_a, 0);
    chk("flt_freq", f_a, 0);
    chk("flt_u", u_a, 0);
    chk("flt_flag", flt_a, 1);
    chk("flt_boot", bl_a, 0);
    clear_fault = 1;
    step(1);
    chk("clr_blocked", st_a, 5);
    fault_in = 0;
    step(1);
    chk("clr_state", st_a, 0);
    chk("clr_flag", flt_a, 0);
    clear_fault = 0;
    start_a = 1;
    step(1);
    start_a = 0;
    step(2);
    stop = 1;
    step(1);
    chk("boot_stop", st_a, 0);
    chk("boot_stop_bl", bl_a, 0);
    stop = 0;
    target_freq = 10;
    ramp_div = 0;
    start_b = 1;
    step(1);
    start_b = 0;
    n = 0;
    while (st_b != 2 && n < 100) begin step(1); n++; end
    chk("b_ramp", st_b, 2);
    step(1);
    chk("b_f1", f_b, 3);
    step(1);
    chk("b_f2", f_b, 6);
    step(1);
    chk("b_f3", f_b, 9);
    step(1);
    chk("b_f4", f_b, 10);
    step(1);
    chk("b_run", run_b, 1);
    target_freq = 4095;
    start_c = 1;
    step(1);
    start_c = 0;
    n = 0;
    while (st_c != 2 && n < 100) begin step(1); n++; end
    chk("c_ramp", st_c, 2);
    chk("c_f0", f_c, 0);
    chk("c_u0", u_c, BC);
    step(1);
    chk("c_f", f_c, 4095);
    step(1);
    chk("c_run", run_c, 1);
    chk("c_sat", u_c, 4095);
    rst = 1;
    step(1);
    chk("mid_rst_state", st_c, 0);
    chk("mid_rst_freq", f_c, 0);
    chk("mid_rst_u", u_c, 0);
    chk("mid_rst_en", en_c, 0);
    chk("mid_rst_run", run_c, 0);
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
